ccd_line_rx: RTL and testbench

- Receive side of the CCD trigger path: captures the line-scan camera's returned lines (line-valid strobe plus pixel data) for one raster acquisition of xdata_points_number × ydata_points_number lines.
- Tags each pixel with its raster x/y position and buffers it in a small FIFO.
- Emits the pixels as a ready/valid stream toward the DMA/packer.
- Detects missing lines (timeout), wrong line length and FIFO overflow.

---
 rtl/ccd_line_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_ccd_line_rx.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_line_rx.sv
// Line-scan camera receiver: tags each pixel with raster x/y, buffers it in a FWFT FIFO, streams ready/valid.
// Pixel sampled on edge n is written on edge n+1; a full FIFO without a pop drops the pixel and flags overflow.
module ccd_line_rx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [15:0]       xdata_points_number,
  input  logic [15:0]       ydata_points_number,
  input  logic [15:0]       pixels_per_line,
  input  logic [31:0]       timeout_cycles,
  input  logic              cam_lval,
  input  logic [DATA_W-1:0] cam_data,
  output logic [DATA_W-1:0] m_tdata,
  output logic [15:0]       m_tx,
  output logic [15:0]       m_ty,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_length,
  output logic              err_overflow
);

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [15:0]       x;
    logic [15:0]       y;
    logic              last;
    logic              user;
  } ent_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_RECV  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [2:0]         r_state;
  logic [15:0]        r_xnum;
  logic [15:0]        r_ppl;
  logic [31:0]        r_tmo;
  logic [31:0]        r_total;
  logic [15:0]        r_x;
  logic [15:0]        r_y;
  logic [15:0]        r_pix;
  logic [31:0]        r_lines;
  logic [31:0]        r_tcnt;
  logic               r_in_vld;
  ent_t               r_in;
  logic               r_busy;
  logic               r_done;
  logic               r_err_timeout;
  logic               r_err_length;
  logic               r_err_overflow;

  ent_t               r_mem [0:FIFO_DEPTH-1];
  logic [FIFO_AW-1:0] r_wp;
  logic [FIFO_AW-1:0] r_rp;
  logic [FIFO_AW:0]   r_cnt;

  logic               w_tvalid;
  logic               w_pop;
  logic               w_push;
  logic               w_flush;
  logic               w_cap;
  logic [15:0]        w_cap_pix;
  ent_t               w_cap_ent;
  ent_t               w_head;

  assign w_tvalid = (r_cnt != '0);
  assign w_pop    = w_tvalid && m_tready;
  assign w_push   = r_in_vld && ((r_cnt != DEPTH_C) || w_pop);
  assign w_flush  = (r_state == S_WAIT) && !cam_lval && (r_tmo != 32'd0) &&
                    (r_tcnt == r_tmo - 32'd1);

  // The first pixel of a line is taken in WAIT_LINE, so its index is 0 there.
  always_comb begin
    w_cap_pix      = (r_state == S_WAIT) ? 16'd0 : r_pix;
    w_cap          = cam_lval && ((r_state == S_WAIT) ||
                                  ((r_state == S_RECV) && (r_pix < r_ppl)));
    w_cap_ent.dat  = cam_data;
    w_cap_ent.x    = r_x;
    w_cap_ent.y    = r_y;
    w_cap_ent.last = (w_cap_pix == r_ppl - 16'd1);
    w_cap_ent.user = (r_x == 16'd0) && (r_y == 16'd0) && (w_cap_pix == 16'd0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_xnum         <= '0;
      r_ppl          <= '0;
      r_tmo          <= '0;
      r_total        <= '0;
      r_x            <= '0;
      r_y            <= '0;
      r_pix          <= '0;
      r_lines        <= '0;
      r_tcnt         <= '0;
      r_in_vld       <= 1'b0;
      r_in           <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_length   <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_in_vld <= w_cap;
      if (w_cap) r_in <= w_cap_ent;
      if (r_in_vld && !w_push) r_err_overflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_xnum         <= xdata_points_number;
            r_ppl          <= pixels_per_line;
            r_tmo          <= timeout_cycles;
            r_total        <= {16'd0, xdata_points_number} * {16'd0, ydata_points_number};
            r_x            <= '0;
            r_y            <= '0;
            r_pix          <= '0;
            r_lines        <= '0;
            r_tcnt         <= '0;
            r_busy         <= 1'b1;
            r_err_timeout  <= 1'b0;
            r_err_length   <= 1'b0;
            r_err_overflow <= 1'b0;
            if ((xdata_points_number == 16'd0) || (ydata_points_number == 16'd0) ||
                (pixels_per_line == 16'd0))
              r_state <= S_DRAIN;
            else
              r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cam_lval) begin
            r_state <= S_RECV;
            r_pix   <= 16'd1;
            r_tcnt  <= '0;
          end else if (w_flush) begin
            r_state       <= S_ABORT;
            r_err_timeout <= 1'b1;
            r_in_vld      <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 32'd1;
          end
        end
        S_RECV: begin
          if (cam_lval) begin
            if (r_pix >= r_ppl) r_err_length <= 1'b1;
            if (r_pix != 16'hFFFF) r_pix <= r_pix + 16'd1;
          end else begin
            if (r_pix < r_ppl) r_err_length <= 1'b1;
            if (r_x == r_xnum - 16'd1) begin
              r_x <= '0;
              r_y <= r_y + 16'd1;
            end else begin
              r_x <= r_x + 16'd1;
            end
            r_lines <= r_lines + 32'd1;
            r_tcnt  <= '0;
            r_state <= (r_lines + 32'd1 == r_total) ? S_DRAIN : S_WAIT;
          end
        end
        S_DRAIN: begin
          if ((r_cnt == '0) && !r_in_vld) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ABORT: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A timeout empties the FIFO on the same edge that enters ABORT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_flush) r_mem[r_wp] <= r_in;
  end

  assign w_head       = r_mem[r_rp];
  assign m_tvalid     = w_tvalid;
  assign m_tdata      = w_tvalid ? w_head.dat  : '0;
  assign m_tx         = w_tvalid ? w_head.x    : '0;
  assign m_ty         = w_tvalid ? w_head.y    : '0;
  assign m_tlast      = w_tvalid ? w_head.last : 1'b0;
  assign m_tuser      = w_tvalid ? w_head.user : 1'b0;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_timeout  = r_err_timeout;
  assign err_length   = r_err_length;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_ccd_line_rx.sv
// Bench for ccd_line_rx: random pixel data, expected beats built from raster position arithmetic.
module tb_ccd_line_rx;
  typedef struct packed {
    logic [15:0] d;
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
    logic        user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] xn = '0;
  logic [15:0] yn = '0;
  logic [15:0] ppl = '0;
  logic [31:0] tmo = '0;
  logic        cam_lval = 1'b0;
  logic [15:0] cam_data = '0;
  logic        m_tready = 1'b0;
  logic [15:0] m_tdata;
  logic [15:0] m_tx;
  logic [15:0] m_ty;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tvalid;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        err_length;
  logic        err_overflow;

  int checks = 0;
  int failures = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  int done_cnt = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int done_cyc = 0;
  int line_no = 0;
  int cx = 1;
  int cp = 1;

  ccd_line_rx #(.DATA_W(16), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .xdata_points_number(xn), .ydata_points_number(yn),
    .pixels_per_line(ppl), .timeout_cycles(tmo),
    .cam_lval(cam_lval), .cam_data(cam_data),
    .m_tdata(m_tdata), .m_tx(m_tx), .m_ty(m_ty), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .err_length(err_length), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake seen at the negedge is the one the next posedge completes.
  always @(negedge clk) begin
    if (rstn && m_tvalid && m_tready) begin
      got_q.push_back(beat_t'({m_tdata, m_tx, m_ty, m_tlast, m_tuser}));
      last_pop_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int x, input int y, input int p, input int t);
    xn = 16'(x); yn = 16'(y); ppl = 16'(p); tmo = 32'(t);
    start = 1'b1;
    tick();
    start = 1'b0;
    cx = (x == 0) ? 1 : x;
    cp = p;
    line_no = 0;
    xn = 16'($urandom); yn = 16'($urandom); ppl = 16'($urandom); tmo = $urandom;
  endtask

  // A line of len pixels; at most keep of the in-range ones survive a stalled FIFO.
  task automatic send_line(input int len, input int gap, input int keep);
    beat_t b;
    for (int p = 0; p < len; p++) begin
      cam_lval = 1'b1;
      cam_data = 16'($urandom);
      if (p < cp && p < keep) begin
        b.d = cam_data;
        b.x = 16'(line_no % cx);
        b.y = 16'(line_no / cx);
        b.last = (p == cp - 1);
        b.user = (line_no == 0) && (p == 0);
        exp_q.push_back(b);
      end
      tick();
    end
    cam_lval = 1'b0;
    cam_data = 16'($urandom);
    repeat (gap) tick();
    line_no++;
  endtask

  task automatic wait_done(input int base, input int budget);
    for (int i = 0; i < budget && done_cnt == base; i++) tick();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({m_tvalid, busy, done, err_timeout, err_length, err_overflow} !== 6'd0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000",
        {m_tvalid, busy, done, err_timeout, err_length, err_overflow});
    end
    rstn = 1'b1;
    tick();
    checks++;
    if ({m_tdata, m_tx, m_ty, m_tlast, m_tuser} !== 50'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {m_tdata, m_tx, m_ty, m_tlast, m_tuser});
    end
  endtask

  task automatic test_basic();
    int gb = got_q.size(); int eb = exp_q.size(); int db = done_cnt;
    m_tready = 1'b1;
    do_start(2, 2, 4, 0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    for (int l = 0; l < 4; l++) send_line(4, 2, 99);
    wait_done(db, 200);
    checks++;
    if (got_q.size() - gb != 16) begin failures++; $display("FAIL basic_count got=%0d exp=16", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL basic_beat[%0d] got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++;
    if (done_cnt != db + 1) begin failures++; $display("FAIL basic_done_cnt got=%0d exp=%0d", done_cnt - db, 1); end
    checks++;
    if (done_cyc != last_pop_cyc + 2) begin failures++; $display("FAIL basic_done_time got=%0d exp=%0d", done_cyc - last_pop_cyc, 2); end
    checks++;
    if ({busy, err_timeout, err_length, err_overflow} !== 4'd0) begin
      failures++; $display("FAIL basic_flags got=%b exp=0000", {busy, err_timeout, err_length, err_overflow});
    end
  endtask

  task automatic test_backpressure();
    int gb = got_q.size(); int eb = exp_q.size(); int db = done_cnt;
    m_tready = 1'b0;
    do_start(2, 2, 4, 0);
    send_line(4, 2, 99);
    checks++;
    if (beat_t'({m_tdata, m_tx, m_ty, m_tlast, m_tuser}) !== exp_q[eb] || m_tvalid !== 1'b1) begin
      failures++; $display("FAIL bp_head got=%h exp=%h", {m_tdata, m_tx, m_ty, m_tlast, m_tuser}, exp_q[eb]);
    end
    send_line(4, 3, 99);
    checks++;
    if (beat_t'({m_tdata, m_tx, m_ty, m_tlast, m_tuser}) !== exp_q[eb] || got_q.size() != gb) begin
      failures++; $display("FAIL bp_stable got=%h exp=%h", {m_tdata, m_tx, m_ty, m_tlast, m_tuser}, exp_q[eb]);
    end
    m_tready = 1'b1;
    send_line(4, 2, 99);
    send_line(4, 2, 99);
    wait_done(db, 200);
    checks++;
    if (got_q.size() - gb != 16) begin failures++; $display("FAIL bp_count got=%0d exp=16", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL bp_beat[%0d] got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++;
    if ({err_overflow, done_cnt == db + 1} !== 2'b01) begin
      failures++; $display("FAIL bp_ovf_done got=%b/%0d exp=0/1", err_overflow, done_cnt - db);
    end
  endtask

  task automatic test_overflow();
    int gb = got_q.size(); int eb = exp_q.size(); int db = done_cnt;
    m_tready = 1'b0;
    do_start(2, 1, 40, 0);
    send_line(40, 2, 16);
    checks++;
    if ({err_overflow, m_tvalid} !== 2'b11) begin failures++; $display("FAIL ovf_flag got=%b exp=11", {err_overflow, m_tvalid}); end
    m_tready = 1'b1;
    send_line(40, 2, 1000);
    wait_done(db, 300);
    checks++;
    if (got_q.size() - gb != 56) begin failures++; $display("FAIL ovf_count got=%0d exp=56", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL ovf_beat[%0d] got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++;
    if (done_cnt != db + 1 || err_length !== 1'b0) begin
      failures++; $display("FAIL ovf_done got=%0d/%b exp=1/0", done_cnt - db, err_length);
    end
  endtask

  task automatic test_length();
    int gb = got_q.size(); int eb = exp_q.size(); int db = done_cnt;
    m_tready = 1'b1;
    do_start(2, 1, 4, 0);
    send_line(3, 2, 99);
    checks++;
    if (err_length !== 1'b1) begin failures++; $display("FAIL len_short got=%b exp=1", err_length); end
    send_line(6, 2, 99);
    wait_done(db, 200);
    checks++;
    if (got_q.size() - gb != 7) begin failures++; $display("FAIL len_count got=%0d exp=7", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL len_beat[%0d] got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++;
    if ({err_length, err_overflow, done_cnt == db + 1} !== 3'b101) begin
      failures++; $display("FAIL len_flags got=%b%b/%0d exp=10/1", err_length, err_overflow, done_cnt - db);
    end
  endtask

  task automatic test_timeout();
    int gb = got_q.size(); int eb; int db = done_cnt;
    m_tready = 1'b0;
    do_start(2, 2, 4, 100);
    send_line(4, 0, 99);
    repeat (100) tick();
    checks++;
    if ({err_timeout, m_tvalid} !== 2'b01) begin failures++; $display("FAIL tmo_early got=%b exp=01", {err_timeout, m_tvalid}); end
    tick();
    checks++;
    if ({err_timeout, m_tvalid, busy} !== 3'b101) begin failures++; $display("FAIL tmo_edge got=%b exp=101", {err_timeout, m_tvalid, busy}); end
    tick();
    checks++;
    if ({done, busy} !== 2'b10) begin failures++; $display("FAIL tmo_done got=%b exp=10", {done, busy}); end
    m_tready = 1'b1;
    repeat (5) tick();
    checks++;
    if (got_q.size() != gb || done_cnt != db + 1) begin
      failures++; $display("FAIL tmo_flush got=%0d/%0d exp=0/1", got_q.size() - gb, done_cnt - db);
    end
    eb = exp_q.size(); gb = got_q.size(); db = done_cnt;
    do_start(1, 1, 2, 0);
    checks++;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", err_timeout); end
    send_line(2, 2, 99);
    wait_done(db, 100);
    checks++;
    if (got_q.size() - gb != 2 || done_cnt != db + 1) begin
      failures++; $display("FAIL tmo_rerun got=%0d/%0d exp=2/1", got_q.size() - gb, done_cnt - db);
    end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL tmo_beat[%0d] got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
  endtask

  task automatic test_misc();
    int gb = got_q.size(); int eb; int db = done_cnt;
    m_tready = 1'b1;
    do_start(0, 3, 4, 0);
    wait_done(db, 50);
    checks++;
    if (done_cnt != db + 1 || got_q.size() != gb || busy !== 1'b0) begin
      failures++; $display("FAIL zero_cfg got=%0d/%0d/%b exp=1/0/0", done_cnt - db, got_q.size() - gb, busy);
    end
    gb = got_q.size(); eb = exp_q.size(); db = done_cnt;
    do_start(2, 1, 3, 0);
    tick();
    xn = 16'd1; yn = 16'd1; ppl = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    send_line(3, 2, 99);
    send_line(3, 2, 99);
    wait_done(db, 100);
    checks++;
    if (got_q.size() - gb != 6 || done_cnt != db + 1 || err_length !== 1'b0) begin
      failures++; $display("FAIL busy_start got=%0d/%0d/%b exp=6/1/0", got_q.size() - gb, done_cnt - db, err_length);
    end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL busy_beat[%0d] got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    db = done_cnt;
    m_tready = 1'b0;
    do_start(2, 1, 4, 0);
    cam_lval = 1'b1; cam_data = 16'h1234;
    tick(); tick();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, busy, done, err_timeout, err_length, err_overflow, m_tdata, m_tx, m_ty, m_tlast, m_tuser} !== 56'd0) begin
      failures++; $display("FAIL async_rst got=%b%b%b exp=000", m_tvalid, busy, done);
    end
    cam_lval = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    repeat (3) tick();
    checks++;
    if (done_cnt != db || busy !== 1'b0) begin failures++; $display("FAIL rst_nodone got=%0d/%b exp=0/0", done_cnt - db, busy); end
    gb = got_q.size(); eb = exp_q.size();
    m_tready = 1'b1;
    do_start(2, 1, 4, 0);
    send_line(4, 2, 99);
    send_line(4, 2, 99);
    wait_done(db, 100);
    checks++;
    if (got_q.size() - gb != 8 || done_cnt != db + 1 ||
        {err_timeout, err_length, err_overflow} !== 3'd0) begin
      failures++; $display("FAIL rst_rerun got=%0d/%0d exp=8/1", got_q.size() - gb, done_cnt - db);
    end
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL rst_beat[%0d] got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_length();
    test_timeout();
    test_misc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1);
  end

endmodule
